vga_fb_arbiter: RTL

- Shares one single-port synchronous frame-buffer RAM between two users: the 800x600@60 display read path and a host pixel writer.
- Sits between the VGA sync generator (consumes its VSYNC and Ready signals) and the frame RAM.
- Display reads have absolute priority while Ready is high. Host writes are buffered in a one-entry holding register and drained only in blanking cycles.

---
 rtl/vga_fb_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous frame RAM between the
// display read path (absolute priority while ready_sig is high) and a host
// pixel writer that is buffered in a one-entry holding register and drained
// only in blanking cycles.
//
// Host handshake: a write transfers on a rising vga_clk edge where
// wr_req & wr_ready are both high. The host keeps wr_req, wr_addr and wr_data
// stable until that edge. wr_ready is ~hold_valid, decoded from registered
// state only, so it never depends combinationally on wr_req.
module vga_fb_arbiter #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 19,
   parameter int FRAME_PIX   = 480000,
   parameter int VBLANK_ONLY = 0
) (
   input  logic              vga_clk,
   input  logic              rst_n,
   input  logic              vsync_sig,
   input  logic              ready_sig,
   input  logic              wr_req,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   output logic              frame_done,
   output logic              dbg_hold_state
);

   localparam logic [ADDR_W-1:0] LP_LAST_PIX = ADDR_W'(FRAME_PIX - 1);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } hold_state_t;

   hold_state_t       r_hold_state;
   hold_state_t       w_hold_next;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W-1:0] r_hold_addr;
   logic [DATA_W-1:0] r_hold_data;
   logic              r_hold_oor;
   logic              r_pix_valid;
   logic              r_frame_done;
   logic              r_wr_err;

   logic              w_hold_valid;
   logic              w_accept;
   logic              w_addr_oor;
   logic              w_drain_ok;
   logic              w_drain;

   assign w_hold_valid = (r_hold_state == ST_FULL);
   assign w_accept     = wr_req & ~w_hold_valid;
   assign w_addr_oor   = (32'(wr_addr) >= 32'(FRAME_PIX));

   // Drain window: any non-active cycle, or only the vertical blank before VSYNC.
   always_comb begin
      w_drain_ok = 1'b1;
      if (VBLANK_ONLY != 0) begin
         w_drain_ok = r_frame_done & vsync_sig;
      end
   end

   // An out-of-range entry is dropped, never written to the RAM.
   assign w_drain = ~ready_sig & w_drain_ok & w_hold_valid & ~r_hold_oor;

   // Display read pointer: restarts on VSYNC low, counts active pixels, wraps per frame.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr     <= '0;
         r_frame_done <= 1'b0;
      end else if (!vsync_sig) begin
         r_rd_ptr     <= '0;
         r_frame_done <= 1'b0;
      end else if (ready_sig) begin
         if (r_rd_ptr == LP_LAST_PIX) begin
            r_rd_ptr     <= '0;
            r_frame_done <= 1'b1;
         end else begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
      end
   end

   // Pixel qualifier follows ready_sig by one cycle, matching the RAM read latency.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pix_valid <= 1'b0;
      end else begin
         r_pix_valid <= ready_sig;
      end
   end

   // Holding FSM state register.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_state <= ST_EMPTY;
      end else begin
         r_hold_state <= w_hold_next;
      end
   end

   // Holding FSM next state: fill on accept, empty after a drain or a dropped entry.
   always_comb begin
      w_hold_next = r_hold_state;
      case (r_hold_state)
         ST_EMPTY: if (w_accept) w_hold_next = ST_FULL;
         ST_FULL:  if (w_drain || r_hold_oor) w_hold_next = ST_EMPTY;
         default:  w_hold_next = ST_EMPTY;
      endcase
   end

   // Holding payload capture and sticky out-of-range error.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_addr <= '0;
         r_hold_data <= '0;
         r_hold_oor  <= 1'b0;
         r_wr_err    <= 1'b0;
      end else if (w_accept) begin
         r_hold_addr <= wr_addr;
         r_hold_data <= wr_data;
         r_hold_oor  <= w_addr_oor;
         if (w_addr_oor) begin
            r_wr_err <= 1'b1;
         end
      end
   end

   // RAM port mux: reads own the port during active video, drains take idle cycles.
   always_comb begin
      ram_addr  = r_rd_ptr;
      ram_we    = 1'b0;
      ram_wdata = '0;
      if (w_drain) begin
         ram_addr  = r_hold_addr;
         ram_we    = 1'b1;
         ram_wdata = r_hold_data;
      end
   end

   assign wr_ready       = ~w_hold_valid;
   assign wr_err         = r_wr_err;
   assign pix_valid      = r_pix_valid;
   assign pix_data       = r_pix_valid ? ram_rdata : '0;
   assign frame_done     = r_frame_done;
   assign dbg_hold_state = r_hold_state;

endmodule
